// File: rtl/data_buffer_ctrl.sv
// data_buffer_ctrl: circular word FIFO between the AHB subordinate and the compute
// array. Words arrive tagged as weight or input. A phase FSM dispatches all weight
// words first, then input words, over a valid/ready stream. It also flags ordering
// and overrun errors.
//
// Optional feature: define DBUF_ALMOST_FULL_EN to add the almost_full output
// (registered count >= DEPTH-2).
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   push_en         write strobe; push_data / push_is_weight give the word and its tag
//   start           pulse: begin dispatch (honoured only in IDLE)
//   clear           synchronous flush of FIFO, flags and FSM
//   out_ready       downstream accepts the head word
//   out_valid       head word is presentable in the current phase
//   out_data        head word
//   out_is_weight   head tag
//   weights_done    pulse: weight phase finished
//   count           occupancy
//   full, empty     occupancy flags
//   busy            FSM is in WEIGHT or INPUT
//   overrun_err     sticky: push dropped while full
//   order_err       sticky: weight word reached the head during the input phase
//   almost_full     (DBUF_ALMOST_FULL_EN only) count >= DEPTH-2
module data_buffer_ctrl #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_en,
  input  logic [DATA_W-1:0]      push_data,
  input  logic                   push_is_weight,
  input  logic                   start,
  input  logic                   clear,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_is_weight,
  output logic                   weights_done,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   busy,
  output logic                   overrun_err,
  output logic                   order_err
`ifdef DBUF_ALMOST_FULL_EN
  ,
  output logic                   almost_full
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WEIGHT, S_INPUT, S_ERR} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic              mem_tag  [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [CW-1:0]     count_next;
  logic              popped_input;
  logic              flush;
  logic              pop;
  logic              push_acc;
  logic              head_tag;

  assign flush         = rst | clear;
  assign head_tag      = mem_tag[rd_ptr];
  assign out_data      = mem_data[rd_ptr];
  assign out_is_weight = head_tag;

  // Head is offered only when its tag matches the current phase.
  always_comb begin
    out_valid = 1'b0;
    case (state)
      S_WEIGHT: out_valid = !empty && head_tag;
      S_INPUT:  out_valid = !empty && !head_tag;
      default:  out_valid = 1'b0;
    endcase
  end

  assign weights_done = (state == S_WEIGHT) && !empty && !head_tag;
  assign busy         = (state == S_WEIGHT) || (state == S_INPUT);

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop      = out_valid & out_ready;
  assign push_acc = push_en & (!full | pop);

  // Next occupancy.
  always_comb begin
    count_next = count;
    if (push_acc && !pop) begin
      count_next = count + CW'(1);
    end else if (!push_acc && pop) begin
      count_next = count - CW'(1);
    end
  end

  // Storage, pointers and occupancy flags. Pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (flush) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      overrun_err <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_data[AW'(i)] <= '0;
        mem_tag[AW'(i)]  <= 1'b0;
      end
    end else begin
      if (push_acc) begin
        mem_data[wr_ptr] <= push_data;
        mem_tag[wr_ptr]  <= push_is_weight;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_en && !push_acc) begin
        overrun_err <= 1'b1;
      end
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

  // Phase FSM. popped_input keeps the input phase from ending before any input word has left.
  always_ff @(posedge clk) begin
    if (flush) begin
      state        <= S_IDLE;
      order_err    <= 1'b0;
      popped_input <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state        <= S_WEIGHT;
            popped_input <= 1'b0;
          end
        end
        S_WEIGHT: begin
          if (!empty && !head_tag) begin
            state <= S_INPUT;
          end
        end
        S_INPUT: begin
          if (!empty && head_tag) begin
            state     <= S_ERR;
            order_err <= 1'b1;
          end else if (empty && popped_input) begin
            state <= S_IDLE;
          end else if (pop) begin
            popped_input <= 1'b1;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

`ifdef DBUF_ALMOST_FULL_EN
  // Early warning two entries before full.
  always_ff @(posedge clk) begin
    if (flush) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (count_next >= CW'(DEPTH - 2));
    end
  end
`endif

endmodule
